// File: rtl/wave_spike_if.sv
// wave_spike_if: sample/control inputs and spike/counter outputs of the spike encoder
interface wave_spike_if #(parameter int CNT_WIDTH = 16);
  logic                 enable;
  logic                 sample_tick;
  logic [31:0]          wave;
  logic                 count_clear;
  logic                 spike_strobe;
  logic                 spike;
  logic [CNT_WIDTH-1:0] spike_count;
  logic [CNT_WIDTH-1:0] drop_count;
  logic [31:0]          acc;
  modport master (
    output enable, sample_tick, wave, count_clear,
    input  spike_strobe, spike, spike_count, drop_count, acc
  );
  modport slave (
    input  enable, sample_tick, wave, count_clear,
    output spike_strobe, spike, spike_count, drop_count, acc
  );
endinterface

// File: rtl/wave_spike_encoder.sv
// wave_spike_encoder: phase-accumulator rate-to-spike encoder with refractory period and counters
module wave_spike_encoder #(
  parameter int PULSE_CYCLES     = 4,
  parameter int REFRACTORY_TICKS = 2,
  parameter int CNT_WIDTH        = 16
) (
  input logic        clk,
  input logic        reset,
  wave_spike_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, REFRACT} state_t;
  state_t               state_q, state_d;
  logic [31:0]          acc_q, acc_d;
  logic [7:0]           refr_q, refr_d;
  logic [7:0]           pulse_q, pulse_d;
  logic                 strobe_q, strobe_d;
  logic                 spike_q, spike_d;
  logic [CNT_WIDTH-1:0] spike_cnt_q, spike_cnt_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic [32:0]          sum;
  // next state: accumulate on ticks, emit or suppress carries, stretch the pulse, maintain counters
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    refr_d      = refr_q;
    pulse_d     = (pulse_q != 8'd0) ? pulse_q - 8'd1 : 8'd0;
    strobe_d    = 1'b0;
    spike_cnt_d = spike_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    sum         = {1'b0, acc_q} + {1'b0, bus.wave};
    if (state_q == IDLE) begin
      acc_d   = '0;
      refr_d  = '0;
      state_d = bus.enable ? RUN : IDLE;
    end else if (!bus.enable) begin
      acc_d   = '0;
      refr_d  = '0;
      state_d = IDLE;
    end else if (bus.sample_tick) begin
      acc_d = sum[31:0];
      if (state_q == RUN) begin
        if (sum[32]) begin
          strobe_d    = 1'b1;
          pulse_d     = 8'(PULSE_CYCLES);
          spike_cnt_d = spike_cnt_q + CNT_WIDTH'(spike_cnt_q != '1);
          refr_d      = 8'(REFRACTORY_TICKS);
          state_d     = (REFRACTORY_TICKS > 0) ? REFRACT : RUN;
        end
      end else begin
        drop_cnt_d = drop_cnt_q + CNT_WIDTH'(sum[32] && drop_cnt_q != '1);
        refr_d     = refr_q - 8'd1;
        state_d    = (refr_q <= 8'd1) ? RUN : REFRACT;
      end
    end
    spike_cnt_d = bus.count_clear ? '0 : spike_cnt_d;
    drop_cnt_d  = bus.count_clear ? '0 : drop_cnt_d;
    spike_d     = pulse_d != 8'd0;
  end
  // state register; reset drops everything including any pulse in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      refr_q      <= '0;
      pulse_q     <= '0;
      strobe_q    <= 1'b0;
      spike_q     <= 1'b0;
      spike_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      refr_q      <= refr_d;
      pulse_q     <= pulse_d;
      strobe_q    <= strobe_d;
      spike_q     <= spike_d;
      spike_cnt_q <= spike_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end
  assign bus.spike_strobe = strobe_q;
  assign bus.spike        = spike_q;
  assign bus.spike_count  = spike_cnt_q;
  assign bus.drop_count   = drop_cnt_q;
  assign bus.acc          = acc_q;
endmodule

// File: tb/tb_wave_spike_encoder.sv
// tb_wave_spike_encoder: three parameterisations driven in lockstep against an arithmetic reference model
module tb_wave_spike_encoder;
  logic clk = 1'b0;
  logic rst, en, tick, clr;
  logic [31:0] wave;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  wave_spike_if #(.CNT_WIDTH(16)) ia ();
  wave_spike_if #(.CNT_WIDTH(16)) ib ();
  wave_spike_if #(.CNT_WIDTH(4))  ic ();
  assign ia.enable = en;  assign ia.sample_tick = tick; assign ia.wave = wave; assign ia.count_clear = clr;
  assign ib.enable = en;  assign ib.sample_tick = tick; assign ib.wave = wave; assign ib.count_clear = clr;
  assign ic.enable = en;  assign ic.sample_tick = tick; assign ic.wave = wave; assign ic.count_clear = clr;
  wave_spike_encoder #(.PULSE_CYCLES(4), .REFRACTORY_TICKS(0), .CNT_WIDTH(16)) dut_a (.clk(clk), .reset(rst), .bus(ia));
  wave_spike_encoder #(.PULSE_CYCLES(4), .REFRACTORY_TICKS(2), .CNT_WIDTH(16)) dut_b (.clk(clk), .reset(rst), .bus(ib));
  wave_spike_encoder #(.PULSE_CYCLES(3), .REFRACTORY_TICKS(0), .CNT_WIDTH(4))  dut_c (.clk(clk), .reset(rst), .bus(ic));
  int     p_cyc[3] = '{4, 4, 3};
  int     r_tck[3] = '{0, 2, 0};
  int     c_w[3]   = '{16, 16, 4};
  longint cyc = 0;
  bit     m_run[3];
  longint m_acc[3], m_sup[3], m_sc[3], m_dc[3], m_pend[3];
  bit     m_str[3];
  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic model_edge();
    longint s, mx;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      mx = (longint'(1) << c_w[i]) - 1;
      m_str[i] = 1'b0;
      if (rst) begin
        m_run[i] = 0; m_acc[i] = 0; m_sup[i] = 0; m_sc[i] = 0; m_dc[i] = 0; m_pend[i] = cyc - 1;
      end else begin
        if (!m_run[i]) begin
          m_acc[i] = 0; m_sup[i] = 0; m_run[i] = en;
        end else if (!en) begin
          m_run[i] = 0; m_acc[i] = 0; m_sup[i] = 0;
        end else if (tick) begin
          s = m_acc[i] + longint'(wave);
          m_acc[i] = s % 64'h1_0000_0000;
          if (m_sup[i] > 0) begin
            if (s >= 64'h1_0000_0000 && m_dc[i] < mx) m_dc[i]++;
            m_sup[i]--;
          end else if (s >= 64'h1_0000_0000) begin
            if (m_sc[i] < mx) m_sc[i]++;
            m_str[i] = 1'b1;
            m_pend[i] = cyc + p_cyc[i] - 1;
            m_sup[i] = r_tck[i];
          end
        end
        if (clr) begin m_sc[i] = 0; m_dc[i] = 0; end
      end
    end
  endtask
  task automatic check_all();
    logic [63:0] o_acc[3], o_sc[3], o_dc[3], o_sp[3], o_st[3];
    o_acc = '{64'(ia.acc), 64'(ib.acc), 64'(ic.acc)};
    o_sc  = '{64'(ia.spike_count), 64'(ib.spike_count), 64'(ic.spike_count)};
    o_dc  = '{64'(ia.drop_count), 64'(ib.drop_count), 64'(ic.drop_count)};
    o_sp  = '{64'(ia.spike), 64'(ib.spike), 64'(ic.spike)};
    o_st  = '{64'(ia.spike_strobe), 64'(ib.spike_strobe), 64'(ic.spike_strobe)};
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("acc[%0d]@%0d", i, cyc), o_acc[i], 64'(m_acc[i]));
      chk($sformatf("spike_count[%0d]@%0d", i, cyc), o_sc[i], 64'(m_sc[i]));
      chk($sformatf("drop_count[%0d]@%0d", i, cyc), o_dc[i], 64'(m_dc[i]));
      chk($sformatf("spike[%0d]@%0d", i, cyc), o_sp[i], 64'(cyc <= m_pend[i]));
      chk($sformatf("strobe[%0d]@%0d", i, cyc), o_st[i], 64'(m_str[i]));
    end
  endtask
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check_all();
    end
  endtask
  task automatic restart();
    rst = 1; en = 0; tick = 0; clr = 0;
    step(1);
    rst = 0; en = 1;
    step(1);
  endtask
  initial begin
    rst = 1; en = 0; tick = 0; clr = 0; wave = 0;
    step(2);
    chk("reset_acc", 64'(ia.acc), 0);
    chk("reset_spike", 64'(ia.spike), 0);
    chk("reset_count", 64'(ia.spike_count), 0);
    rst = 0; en = 1; tick = 1; wave = 32'h8000_0000;
    step(1);
    chk("idle_tick_ignored", 64'(ia.acc), 0);
    step(6);
    tick = 0;
    chk("r0_spikes", 64'(ia.spike_count), 3);
    chk("r0_drops", 64'(ia.drop_count), 0);
    chk("r0_acc", 64'(ia.acc), 0);
    chk("r2_spikes6", 64'(ib.spike_count), 2);
    chk("r2_drops6", 64'(ib.drop_count), 1);
    tick = 1;
    step(4);
    tick = 0;
    chk("r2_spikes10", 64'(ib.spike_count), 3);
    chk("r2_drops10", 64'(ib.drop_count), 2);
    restart();
    wave = 32'h4000_0000;
    repeat (8) begin
      tick = 1; step(1);
      tick = 0; step(9);
    end
    chk("quarter_rate_spikes", 64'(ia.spike_count), 2);
    restart();
    wave = 32'h8000_0000; tick = 1;
    step(13);
    chk("retrigger_spike", 64'(ia.spike), 1);
    clr = 1;
    step(1);
    chk("clear_wins_strobe", 64'(ia.spike_strobe), 1);
    chk("clear_wins_count", 64'(ia.spike_count), 0);
    clr = 0; tick = 0; en = 0;
    step(1);
    chk("disable_pulse_runs", 64'(ia.spike), 1);
    chk("disable_acc", 64'(ia.acc), 0);
    chk("disable_drop_count", 64'(ib.drop_count), 0);
    step(5);
    chk("pulse_done", 64'(ia.spike), 0);
    restart();
    wave = 32'hFFFF_FFFF; tick = 1;
    step(22);
    chk("saturate_cnt4", 64'(ic.spike_count), 15);
    chk("mid_pulse_spike", 64'(ic.spike), 1);
    rst = 1; tick = 0;
    step(1);
    chk("rst_mid_spike", 64'(ic.spike), 0);
    chk("rst_mid_count", 64'(ic.spike_count), 0);
    chk("rst_mid_acc", 64'(ib.acc), 0);
    rst = 0;
    repeat (600) begin
      rst  = ($urandom_range(0, 149) == 0);
      en   = ($urandom_range(0, 15) != 0);
      tick = $urandom_range(0, 1) == 1;
      clr  = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0: wave = $urandom;
        1: wave = 32'h8000_0000;
        2: wave = 32'hFFFF_FFFF;
        default: wave = 32'h0;
      endcase
      step(1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
